ac_vlsa: RTL and testbench
==========================

AC_VLSA -- requirements
Module: ac_vlsa

Interface
REQ-001: Parameter WIDTH, default 16, operand and sum width in bits (WIDTH >= 2*WINDOW).
REQ-002: Parameter WINDOW, default 4, carry-speculation window length in bits (2..WIDTH/2).
REQ-003: clk  input  1  sole clock, all state on rising edge.
REQ-004: rst_n  input  1  reset, asynchronous, active-low.
REQ-005: in_valid  input  1  operands present.
REQ-006: in_ready  output  1  block accepts operands this cycle.
REQ-007: a, b  input  WIDTH each  addends.
REQ-008: cin  input  1  carry-in.
REQ-009: mode  input  1  0 = approximate, 1 = exact-on-error; sampled with operands.
REQ-010: out_valid  output  1  result present.
REQ-011: out_ready  input  1  consumer accepts result.
REQ-012: sum  output  WIDTH  result.
REQ-013: cout  output  1  carry-out of result.
REQ-014: err  output  1  speculative result differed from exact sum for this operation.
REQ-015: exact  output  1  sum/cout are the corrected exact values.
REQ-016: err_cnt  output  16  saturating count of accepted operations with err=1.

Function
REQ-017: Speculative carry into bit i SHALL be the exact ripple carry for i < WINDOW, else the group generate of bits i-WINDOW..i-1 with zero carry-in to the window.
REQ-018: Speculative cout SHALL be the group generate of bits WIDTH-WINDOW..WIDTH-1.
REQ-019: err SHALL be 1 iff {cout,sum} of speculation != exact a+b+cin.
REQ-020: FSM states: IDLE, HOLD, FIX; reset state IDLE.
REQ-021: in_ready SHALL be 1 in IDLE, equal out_ready in HOLD, 0 in FIX.
REQ-022: Acceptance (in_valid & in_ready) SHALL capture a, b, cin, mode, speculative result and err.
REQ-023: On acceptance with mode=0 or err=0: next state HOLD, speculative result output, exact = !err, latency 1 cycle.
REQ-024: On acceptance with mode=1 and err=1: next state FIX for exactly one cycle (out_valid=0), then HOLD with exact result, exact=1, latency 2 cycles.
REQ-025: HOLD: out_valid=1; sum, cout, err, exact SHALL remain stable until out_ready=1.
REQ-026: HOLD with out_ready=1 and in_valid=1: handoff and new acceptance in the same cycle; throughput one op/cycle when no FIX occurs.
REQ-027: HOLD with out_ready=1 and in_valid=0: next state IDLE.
REQ-028: FIX SHALL ignore in_valid and out_ready.
REQ-029: err_cnt SHALL increment on every acceptance with err=1 regardless of mode, and hold at 0xFFFF.
REQ-030: Arithmetic modulo 2^WIDTH with cout as bit WIDTH; no other overflow indication.

Reset
REQ-031: rst_n low SHALL immediately force: state IDLE, out_valid=0, sum=0, cout=0, err=0, exact=0, err_cnt=0.
REQ-032: Reset during FIX or HOLD SHALL discard the in-flight operation with no output.
REQ-033: First acceptance possible on the first rising edge after rst_n deasserts.

Structure
REQ-034: Shared package SHALL hold the FSM state enum and the err_cnt width/saturation constant.
REQ-035: One sub-module, win_gp, SHALL compute group generate/propagate over a WINDOW-bit slice (serial prefix), instantiated per speculative bit position.
REQ-036: Exact sum for correction SHALL be computed from registered operands in FIX; no combinational path from a/b to sum.

Verification (WIDTH=16, WINDOW=4)
REQ-037: a=0x1234, b=0x0101, cin=0, mode=0 -> one cycle later sum=0x1335, cout=0, err=0, exact=1.
REQ-038: a=0x00FF, b=0x0001, cin=0, mode=0 -> one cycle later sum=0x00E0, err=1, exact=0, err_cnt=1.
REQ-039: same operands, mode=1 -> out_valid low one cycle, then sum=0x0100, cout=0, err=1, exact=1.
REQ-040: back-to-back 8 error-free ops with out_ready=1 -> 8 results on 8 consecutive cycles; with out_ready=0 for 3 cycles -> sum stable, in_ready=0.
REQ-041: rst_n pulsed low during FIX -> out_valid=0, err_cnt=0, no result emitted; next op behaves as after power-up.
REQ-042: force 65536 err=1 acceptances -> err_cnt=0xFFFF and stays there.

Source files
------------

// File: rtl/ac_vlsa_pkg.sv
// Shared types and constants for the variable-latency speculative adder.
package ac_vlsa_pkg;
    typedef enum logic [1:0] {IDLE, HOLD, FIX} state_t;
    localparam int          ERR_CNT_W   = 16;
    localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;
endpackage

// File: rtl/ac_vlsa_win_gp.sv
// Group generate/propagate over one WINDOW-bit slice, serial prefix from LSB.
module win_gp #(
    parameter int WINDOW = 4
) (
    input  logic [WINDOW-1:0] g,
    input  logic [WINDOW-1:0] p,
    output logic              gg,
    output logic              gp
);
    always_comb begin
        logic gacc;
        logic pacc;
        gacc = 1'b0;
        pacc = 1'b1;
        for (int k = 0; k < WINDOW; k++) begin
            gacc = g[k] | (p[k] & gacc);
            pacc = pacc & p[k];
        end
        gg = gacc;
        gp = pacc;
    end
endmodule

// File: rtl/ac_vlsa.sv
// Windowed carry-speculation adder; optional one-cycle correction when speculation misses.
module ac_vlsa
    import ac_vlsa_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int WINDOW = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 cin,
    input  logic                 mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     sum,
    output logic                 cout,
    output logic                 err,
    output logic                 exact,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    state_t           state;
    logic [WIDTH-1:0] g, p;
    logic [WIDTH:0]   ex_full;
    logic [WIDTH:0]   spec_c;
    logic [WIDTH-1:0] spec_sum;
    logic             spec_cout, spec_err, accept;
    logic [WIDTH-1:0] a_r, b_r;
    logic             cin_r;

    assign g       = a & b;
    assign p       = a ^ b;
    assign ex_full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

    // Low bits take the true carry; higher bits only see the WINDOW bits below them.
    for (genvar i = 0; i <= WIDTH; i++) begin : g_carry
        if (i < WINDOW) begin : g_exact
            assign spec_c[i] = ex_full[i] ^ p[i];
        end else begin : g_spec
            logic wg, wp;
            win_gp #(.WINDOW(WINDOW)) u_win (
                .g  (g[i-1 -: WINDOW]),
                .p  (p[i-1 -: WINDOW]),
                .gg (wg),
                .gp (wp)
            );
            assign spec_c[i] = wg | (wp & 1'b0);
        end
    end

    assign spec_sum  = p ^ spec_c[WIDTH-1:0];
    assign spec_cout = spec_c[WIDTH];
    assign spec_err  = ({spec_cout, spec_sum} != ex_full);

    always_comb begin
        case (state)
            IDLE:    in_ready = 1'b1;
            HOLD:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            err       <= 1'b0;
            exact     <= 1'b0;
            err_cnt   <= '0;
            a_r       <= '0;
            b_r       <= '0;
            cin_r     <= 1'b0;
        end else begin
            if (accept && spec_err && err_cnt != ERR_CNT_MAX)
                err_cnt <= err_cnt + 1'b1;
            case (state)
                IDLE, HOLD: begin
                    if (accept) begin
                        a_r   <= a;
                        b_r   <= b;
                        cin_r <= cin;
                        err   <= spec_err;
                        if (mode && spec_err) begin
                            state     <= FIX;
                            out_valid <= 1'b0;
                            exact     <= 1'b0;
                        end else begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            sum       <= spec_sum;
                            cout      <= spec_cout;
                            exact     <= !spec_err;
                        end
                    end else if (state == HOLD && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                FIX: begin
                    // Correction uses only registered operands.
                    {cout, sum} <= {1'b0, a_r} + {1'b0, b_r} + {{WIDTH{1'b0}}, cin_r};
                    exact       <= 1'b1;
                    out_valid   <= 1'b1;
                    state       <= HOLD;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ac_vlsa.sv
// Directed checks for ac_vlsa at WIDTH=16, WINDOW=4.
module tb_ac_vlsa;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [15:0] a, b;
    logic        cin, mode;
    logic        out_valid, out_ready;
    logic [15:0] sum;
    logic        cout, err, exact;
    logic [15:0] err_cnt;
    int          checks = 0;
    int          errors = 0;

    ac_vlsa #(.WIDTH(16), .WINDOW(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .mode(mode), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .err(err),
        .exact(exact), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; mode = 1'b0;
        #2;
        checks++;
        if ({out_valid, sum, cout, err, exact, err_cnt} !== 36'h0) begin
            errors++;
            $display("FAIL reset_outputs got ov=%b sum=%h c=%b e=%b x=%b cnt=%h exp all zero",
                     out_valid, sum, cout, err, exact, err_cnt);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready);
        end
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic test_exact_ok();
        a = 16'h1234; b = 16'h0101; cin = 1'b0; mode = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, sum, cout, err, exact} !== {1'b1, 16'h1335, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL exact_ok got ov=%b sum=%h c=%b e=%b x=%b exp 1 1335 0 0 1",
                     out_valid, sum, cout, err, exact);
        end
        step();
        checks++;
        if (sum !== 16'h1335 || out_valid !== 1'b1) begin
            errors++; $display("FAIL hold_stable got ov=%b sum=%h exp 1 1335", out_valid, sum);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL drain_idle got ov=%b exp 0", out_valid);
        end
    endtask

    task automatic test_approx_err();
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; mode = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, sum, cout, err, exact, err_cnt} !==
            {1'b1, 16'h00E0, 1'b0, 1'b1, 1'b0, 16'd1}) begin
            errors++;
            $display("FAIL approx_err got ov=%b sum=%h c=%b e=%b x=%b cnt=%0d exp 1 00e0 0 1 0 1",
                     out_valid, sum, cout, err, exact, err_cnt);
        end
        step();
    endtask

    task automatic test_fix();
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; mode = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL fix_cycle got ov=%b ir=%b exp 0 0", out_valid, in_ready);
        end
        step();
        checks++;
        if ({out_valid, sum, cout, err, exact, err_cnt} !==
            {1'b1, 16'h0100, 1'b0, 1'b1, 1'b1, 16'd2}) begin
            errors++;
            $display("FAIL fix_result got ov=%b sum=%h c=%b e=%b x=%b cnt=%0d exp 1 0100 0 1 1 2",
                     out_valid, sum, cout, err, exact, err_cnt);
        end
        // Carry-in and full carry-out through the correction path.
        a = 16'hFFFF; b = 16'h0000; cin = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if ({out_valid, cout, sum, exact} !== {1'b1, 17'h10000, 1'b1}) begin
            errors++;
            $display("FAIL fix_cout got ov=%b c=%b sum=%h x=%b exp 1 1 0000 1", out_valid, cout, sum, exact);
        end
        mode = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_sum;
        out_ready = 1'b1; mode = 1'b0; cin = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            a = 16'(k); b = 16'(k << 8); in_valid = 1'b1;
            exp_sum = 16'(k) | 16'(k << 8);
            step();
            checks++;
            if (out_valid !== 1'b1 || sum !== exp_sum || err !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_%0d got ov=%b sum=%h e=%b ir=%b exp 1 %h 0 1",
                         k, out_valid, sum, err, in_ready, exp_sum);
            end
        end
        a = 16'h0003; b = 16'h0300; out_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (sum !== 16'h0808 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_%0d got sum=%h ir=%b ov=%b exp 0808 0 1", k, sum, in_ready, out_valid);
            end
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || err_cnt !== 16'd3) begin
            errors++; $display("FAIL b2b_drain got ov=%b cnt=%0d exp 0 3", out_valid, err_cnt);
        end
    endtask

    task automatic test_reset_in_fix();
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; mode = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || err_cnt !== 16'd0 || sum !== 16'h0) begin
            errors++;
            $display("FAIL rst_fix got ov=%b cnt=%0d sum=%h exp 0 0 0000", out_valid, err_cnt, sum);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_fix_noresult got ov=%b exp 0", out_valid);
        end
        a = 16'h1234; b = 16'h0101; mode = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, sum, err, exact, err_cnt} !== {1'b1, 16'h1335, 1'b0, 1'b1, 16'd0}) begin
            errors++;
            $display("FAIL post_rst_op got ov=%b sum=%h e=%b x=%b cnt=%0d exp 1 1335 0 1 0",
                     out_valid, sum, err, exact, err_cnt);
        end
        step();
    endtask

    task automatic test_saturate();
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        repeat (65534) step();
        checks++;
        if (err_cnt !== 16'hFFFE) begin
            errors++; $display("FAIL sat_pre got %h exp fffe", err_cnt);
        end
        step();
        checks++;
        if (err_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL sat_hit got %h exp ffff", err_cnt);
        end
        repeat (4) step();
        checks++;
        if (err_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL sat_hold got %h exp ffff", err_cnt);
        end
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_exact_ok();
        test_approx_err();
        test_fix();
        test_back_to_back();
        test_reset_in_fix();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
